// File: rtl/temp_entry_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// temp_entry_ctrl_pkg
// Shared constants for the temperature entry controller: the input_state
// encodings (also consumed by the display mux and monitor), the FSM state
// enum built on them, and BCD digit helpers.
// -----------------------------------------------------------------------------
package temp_entry_ctrl_pkg;

  localparam logic [1:0] INPUT_STATE_HUNS = 2'd0;
  localparam logic [1:0] INPUT_STATE_TENS = 2'd1;
  localparam logic [1:0] INPUT_STATE_ONES = 2'd2;
  localparam logic [1:0] INPUT_STATE_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_HUNS = INPUT_STATE_HUNS,
    ST_TENS = INPUT_STATE_TENS,
    ST_ONES = INPUT_STATE_ONES,
    ST_DONE = INPUT_STATE_DONE
  } input_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/temp_entry_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces an already-synchronized active-low key and emits a single-cycle
// press pulse on each accepted high-to-low transition.
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   key_n_sync - synchronized key level (0 = pressed)
//   press      - one-cycle pulse per accepted press
//
// A level is accepted after DEBOUNCE_CYCLES consecutive samples that differ
// from the accepted level; any sample back at the accepted level restarts the
// count. Out of reset the block is disarmed: it first has to see a debounced
// release, so a key held through reset cannot produce a press.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_sync,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic             target;
  logic             moving;
  logic             hit;

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    armed_d = armed_q;
    press_d = 1'b0;

    // Before arming, the only level being qualified is "released".
    target = armed_q ? ~acc_q : 1'b1;
    moving = (key_n_sync == target);
    // Down-counter: zero means idle, terminal count is 1 (or the very first
    // differing sample when a single sample is enough).
    hit    = (cnt_q == CNT_ONE) || ((cnt_q == '0) && (DEBOUNCE_CYCLES == 1));

    if (!moving) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = '0;
      if (!armed_q) begin
        armed_d = 1'b1;
      end else begin
        acc_d   = key_n_sync;
        press_d = ~key_n_sync;
      end
    end else if (cnt_q == '0) begin
      cnt_d = CNT_LOAD;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/temp_entry_ctrl.sv
// -----------------------------------------------------------------------------
// temp_entry_ctrl
// Three-digit signed BCD temperature entry from switches and an enter key.
// Digits are shadowed per press and committed atomically on the third press.
//
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   enter_n, sw_digit, sw_sign         - raw asynchronous user inputs
//   input_state                        - entry FSM state (INPUT_STATE_*)
//   current_value                      - synchronized sw_digit for display
//   temp_huns/tens/ones, temp_sign     - committed temperature
//   temp_huns_old/tens_old/ones_old    - previously committed temperature
//   commit                             - one-cycle pulse on commit
//   digit_err                          - one-cycle pulse on rejected digit
//
// Build option: TEMP_ENTRY_BCD_CHECK_EN rejects digits >9 (digit_err pulses);
// without it digits >9 are clamped to 9 and digit_err is tied low.
//
// state | meaning
// HUNS  | waiting for hundreds digit
// TENS  | hundreds shadowed, waiting for tens digit
// ONES  | tens shadowed, next press commits
// DONE  | value committed, next press starts a new entry
// -----------------------------------------------------------------------------
module temp_entry_ctrl
  import temp_entry_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter_n,
  input  logic [3:0] sw_digit,
  input  logic       sw_sign,
  output logic [1:0] input_state,
  output logic [3:0] current_value,
  output logic [3:0] temp_huns,
  output logic [3:0] temp_tens,
  output logic [3:0] temp_ones,
  output logic [3:0] temp_huns_old,
  output logic [3:0] temp_tens_old,
  output logic [3:0] temp_ones_old,
  output logic       temp_sign,
  output logic       commit,
  output logic       digit_err
);

  // Two-flop synchronizers; enter resets to the released level.
  logic       enter_meta_q, enter_sync_q;
  logic       sign_meta_q, sign_sync_q;
  logic [3:0] digit_meta_q, digit_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_meta_q <= 1'b1;
      enter_sync_q <= 1'b1;
      sign_meta_q  <= 1'b0;
      sign_sync_q  <= 1'b0;
      digit_meta_q <= '0;
      digit_sync_q <= '0;
    end else begin
      enter_meta_q <= enter_n;
      enter_sync_q <= enter_meta_q;
      sign_meta_q  <= sw_sign;
      sign_sync_q  <= sign_meta_q;
      digit_meta_q <= sw_digit;
      digit_sync_q <= digit_meta_q;
    end
  end

  logic press;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n_sync (enter_sync_q),
    .press      (press)
  );

  input_state_e state_q, state_d;
  logic [3:0]   huns_sh_q, huns_sh_d;
  logic [3:0]   tens_sh_q, tens_sh_d;
  logic [3:0]   huns_q, huns_d, tens_q, tens_d, ones_q, ones_d;
  logic [3:0]   huns_old_q, huns_old_d, tens_old_q, tens_old_d, ones_old_q, ones_old_d;
  logic         sign_q, sign_d;
  logic         commit_q, commit_d;
  logic         err_d;
  logic         digit_ok;
  logic [3:0]   digit_use;

  always_comb begin
`ifdef TEMP_ENTRY_BCD_CHECK_EN
    digit_ok  = bcd_valid(digit_sync_q);
    digit_use = digit_sync_q;
`else
    digit_ok  = 1'b1;
    digit_use = bcd_clamp(digit_sync_q);
`endif
  end

  always_comb begin
    state_d    = state_q;
    huns_sh_d  = huns_sh_q;
    tens_sh_d  = tens_sh_q;
    huns_d     = huns_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    huns_old_d = huns_old_q;
    tens_old_d = tens_old_q;
    ones_old_d = ones_old_q;
    sign_d     = sign_q;
    commit_d   = 1'b0;
    err_d      = 1'b0;

    if (press) begin
      unique case (state_q)
        ST_HUNS: begin
          if (digit_ok) begin
            huns_sh_d = digit_use;
            state_d   = ST_TENS;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_TENS: begin
          if (digit_ok) begin
            tens_sh_d = digit_use;
            state_d   = ST_ONES;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_ONES: begin
          if (digit_ok) begin
            huns_old_d = huns_q;
            tens_old_d = tens_q;
            ones_old_d = ones_q;
            huns_d     = huns_sh_q;
            tens_d     = tens_sh_q;
            ones_d     = digit_use;
            sign_d     = sign_sync_q;
            commit_d   = 1'b1;
            state_d    = ST_DONE;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_HUNS;
        end
        default: begin
          state_d = ST_HUNS;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNS;
      huns_sh_q  <= '0;
      tens_sh_q  <= '0;
      huns_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      huns_old_q <= '0;
      tens_old_q <= '0;
      ones_old_q <= '0;
      sign_q     <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      huns_sh_q  <= huns_sh_d;
      tens_sh_q  <= tens_sh_d;
      huns_q     <= huns_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      huns_old_q <= huns_old_d;
      tens_old_q <= tens_old_d;
      ones_old_q <= ones_old_d;
      sign_q     <= sign_d;
      commit_q   <= commit_d;
    end
  end

`ifdef TEMP_ENTRY_BCD_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign digit_err = err_q;
`else
  // err_d is never raised when out-of-range digits are clamped.
  logic unused_err;
  assign unused_err = err_d;
  assign digit_err  = 1'b0;
`endif

  assign input_state   = state_q;
  assign current_value = digit_sync_q;
  assign temp_huns     = huns_q;
  assign temp_tens     = tens_q;
  assign temp_ones     = ones_q;
  assign temp_huns_old = huns_old_q;
  assign temp_tens_old = tens_old_q;
  assign temp_ones_old = ones_old_q;
  assign temp_sign     = sign_q;
  assign commit        = commit_q;

endmodule

// File: tb/tb_temp_entry_ctrl.sv
// Directed bench for temp_entry_ctrl with DEBOUNCE_CYCLES=4.
// Press latency from enter_n falling at a negedge: 2 sync edges, 4 debounce
// samples (edges 3..6, press pulse after edge 6), FSM/commit update at edge 7.
module tb_temp_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enter_n;
  logic [3:0] sw_digit;
  logic       sw_sign;
  logic [1:0] input_state;
  logic [3:0] current_value;
  logic [3:0] temp_huns, temp_tens, temp_ones;
  logic [3:0] temp_huns_old, temp_tens_old, temp_ones_old;
  logic       temp_sign;
  logic       commit;
  logic       digit_err;

  int n_checks = 0;
  int n_errors = 0;
  int commit_cnt, commit_at, err_cnt, err_at, chg_cnt;
  logic [1:0] prev_state;

  always #5 clk = ~clk;

  temp_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enter_n       (enter_n),
    .sw_digit      (sw_digit),
    .sw_sign       (sw_sign),
    .input_state   (input_state),
    .current_value (current_value),
    .temp_huns     (temp_huns),
    .temp_tens     (temp_tens),
    .temp_ones     (temp_ones),
    .temp_huns_old (temp_huns_old),
    .temp_tens_old (temp_tens_old),
    .temp_ones_old (temp_ones_old),
    .temp_sign     (temp_sign),
    .commit        (commit),
    .digit_err     (digit_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Samples one cycle at the negedge, tracking pulses and state changes.
  task automatic tick(input int idx);
    @(negedge clk);
    if (commit === 1'b1) begin commit_cnt++; commit_at = idx; end
    if (digit_err === 1'b1) begin err_cnt++; err_at = idx; end
    if (input_state !== prev_state) chg_cnt++;
    prev_state = input_state;
  endtask

  task automatic clr_stats();
    commit_cnt = 0; commit_at = 0; err_cnt = 0; err_at = 0; chg_cnt = 0;
    prev_state = input_state;
  endtask

  task automatic press(input logic [3:0] d);
    sw_digit = d;
    repeat (3) @(negedge clk);
    clr_stats();
    enter_n = 1'b0;
    for (int i = 1; i <= 12; i++) tick(i);
    enter_n = 1'b1;
    for (int i = 13; i <= 24; i++) tick(i);
  endtask

  task automatic chk_temp(input string tag, input logic [11:0] t, input logic [11:0] o,
                          input logic s);
    chk({tag, "_temp"}, {temp_huns, temp_tens, temp_ones}, t);
    chk({tag, "_old"}, {temp_huns_old, temp_tens_old, temp_ones_old}, o);
    chk({tag, "_sign"}, temp_sign, s);
  endtask

  initial begin
    rst_n = 1'b0; enter_n = 1'b1; sw_digit = 4'd0; sw_sign = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", input_state, 2'd0);
    chk_temp("rst", 12'h000, 12'h000, 1'b0);
    chk("rst_commit", commit, 1'b0);
    chk("rst_err", digit_err, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    sw_digit = 4'd5;
    repeat (3) @(negedge clk);
    chk("cur_val_5", current_value, 4'd5);

    // Entry 1,2,5 with sign negative.
    sw_sign = 1'b1;
    press(4'd1);
    chk("e1_state", input_state, 2'd1);
    chk("e1_commits", commit_cnt, 0);
    press(4'd2);
    chk("e2_state", input_state, 2'd2);
    chk_temp("e2_partial", 12'h000, 12'h000, 1'b0);
    press(4'd5);
    chk("e3_state", input_state, 2'd3);
    chk("e3_commits", commit_cnt, 1);
    chk("e3_commit_at", commit_at, 7);
    chk_temp("e3", 12'h125, 12'h000, 1'b1);

    // DONE -> HUNS, then 0,9,8 with sign toggled only before the last press.
    press(4'd4);
    chk("done_state", input_state, 2'd0);
    chk("done_commits", commit_cnt, 0);
    chk_temp("done", 12'h125, 12'h000, 1'b1);
    sw_sign = 1'b0;
    press(4'd0);
    press(4'd9);
    chk("f2_state", input_state, 2'd2);
    chk_temp("f2_partial", 12'h125, 12'h000, 1'b1);
    sw_sign = 1'b1;
    repeat (4) @(negedge clk);
    sw_sign = 1'b0;
    press(4'd8);
    chk("f3_state", input_state, 2'd3);
    chk("f3_commits", commit_cnt, 1);
    chk_temp("f3", 12'h098, 12'h125, 1'b0);

    // Two-cycle bounce must not be accepted.
    clr_stats();
    enter_n = 1'b0;
    for (int i = 1; i <= 2; i++) tick(i);
    enter_n = 1'b1;
    for (int i = 3; i <= 14; i++) tick(i);
    chk("bounce_state", input_state, 2'd3);
    chk("bounce_changes", chg_cnt, 0);

    // Long hold gives exactly one advance.
    clr_stats();
    enter_n = 1'b0;
    for (int i = 1; i <= 100; i++) tick(i);
    enter_n = 1'b1;
    for (int i = 101; i <= 112; i++) tick(i);
    chk("hold_state", input_state, 2'd0);
    chk("hold_changes", chg_cnt, 1);

    // Out-of-range digit in TENS.
    press(4'd3);
    press(4'd12);
`ifdef TEMP_ENTRY_BCD_CHECK_EN
    chk("bad_state", input_state, 2'd1);
    chk("bad_err_cnt", err_cnt, 1);
    chk("bad_err_at", err_at, 7);
    press(4'd9);
`else
    chk("bad_state", input_state, 2'd2);
    chk("bad_err_cnt", err_cnt, 0);
`endif
    chk("bad_ones_state", input_state, 2'd2);
    press(4'd4);
    chk("g3_commits", commit_cnt, 1);
    chk_temp("g3", 12'h394, 12'h098, 1'b0);

    // Reset in ONES with a key held through reset release.
    press(4'd0);
    press(4'd7);
    press(4'd7);
    chk("pre_rst_state", input_state, 2'd2);
    enter_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_state", input_state, 2'd0);
    chk_temp("mid_rst", 12'h000, 12'h000, 1'b0);
    chk("mid_rst_cur", current_value, 4'd0);
    rst_n = 1'b1;
    clr_stats();
    for (int i = 1; i <= 20; i++) tick(i);
    chk("held_changes", chg_cnt, 0);
    enter_n = 1'b1;
    for (int i = 21; i <= 32; i++) tick(i);
    chk("held_state", input_state, 2'd0);

    press(4'd1);
    press(4'd2);
    press(4'd3);
    chk("h3_commits", commit_cnt, 1);
    chk_temp("h3", 12'h123, 12'h000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
